// File: rtl/ddr3_test_status_if.sv
// Byte-wide register readback port of the DDR3 test status block.
// reg_read is a one-cycle strobe with no back-pressure: reg_addr is sampled with it,
// and reg_datao carries the addressed byte from the next cycle until the next strobe.
interface ddr3_test_status_if;
  logic [4:0] reg_addr;
  logic       reg_read;
  logic [7:0] reg_datao;

  modport master (
    output reg_addr,
    output reg_read,
    input  reg_datao
  );

  modport slave (
    input  reg_addr,
    input  reg_read,
    output reg_datao
  );
endinterface

// File: rtl/ddr3_test_status.sv
// Status/statistics stage behind the DDR3 test engine: LEDs, pass counting,
// first-failure capture, cycles-per-iteration and a snapshotted byte readback.
module ddr3_test_status #(
  parameter int pADDR_WIDTH = 30,
  parameter int pBLINK_BITS = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   active,
  input  logic                   init_calib_complete,
  input  logic                   pass,
  input  logic                   fail,
  input  logic [15:0]            iteration,
  input  logic [7:0]             errors,
  input  logic [pADDR_WIDTH-1:0] error_addr,
  input  logic                   clear,
  ddr3_test_status_if.slave      bus,
  output logic                   led_pass,
  output logic                   led_fail,
  output logic                   led_calib,
  output logic                   led_heartbeat
);

  logic [15:0]            iteration_q;
  logic                   fail_q;
  logic [31:0]            cyc_cnt;
  logic [31:0]            cycles_per_iter;
  logic [15:0]            pass_count;
  logic                   fail_seen;
  logic [15:0]            fail_iteration;
  logic [31:0]            fail_addr;
  logic [pBLINK_BITS-1:0] blink;

  logic [15:0] sh_iteration;
  logic [7:0]  sh_errors;
  logic [31:0] sh_error_addr;
  logic [15:0] sh_pass_count;
  logic [15:0] sh_fail_iteration;
  logic [31:0] sh_cycles_per_iter;
  logic [31:0] sh_fail_addr;

  logic        inc;
  logic        fail_rise;
  logic        snap;
  logic [31:0] error_addr_ext;
  logic [7:0]  status_byte;
  logic [7:0]  rd_byte;

  // Only a +1 step (mod 2^16) is an iteration; the engine's drop to 0 on idle is not.
  assign inc            = (iteration == iteration_q + 16'd1);
  assign fail_rise      = fail & ~fail_q;
  assign snap           = bus.reg_read && (bus.reg_addr == 5'h00);
  assign error_addr_ext = 32'(error_addr);
  assign status_byte    = {3'b000, fail_seen, active, init_calib_complete, fail, pass};

  always_ff @(posedge clk) begin
    if (reset) begin
      iteration_q     <= '0;
      fail_q          <= 1'b0;
      cyc_cnt         <= '0;
      cycles_per_iter <= '0;
      pass_count      <= '0;
      fail_seen       <= 1'b0;
      fail_iteration  <= '0;
      fail_addr       <= '0;
    end else begin
      iteration_q <= iteration;
      fail_q      <= fail;

      if (!active || inc) begin
        cyc_cnt <= '0;
      end else if (cyc_cnt != 32'hFFFF_FFFF) begin
        cyc_cnt <= cyc_cnt + 32'd1;
      end

      // clear takes priority over every statistics update in the same cycle.
      if (clear) begin
        cycles_per_iter <= '0;
        pass_count      <= '0;
        fail_seen       <= 1'b0;
        fail_iteration  <= '0;
        fail_addr       <= '0;
      end else begin
        if (inc) begin
          cycles_per_iter <= (cyc_cnt == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : cyc_cnt + 32'd1;
          if (pass && !fail && pass_count != 16'hFFFF) begin
            pass_count <= pass_count + 16'd1;
          end
        end
        if (fail_rise && !fail_seen) begin
          fail_seen      <= 1'b1;
          fail_iteration <= iteration;
          fail_addr      <= error_addr_ext;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink         <= '0;
      led_pass      <= 1'b0;
      led_fail      <= 1'b0;
      led_calib     <= 1'b0;
      led_heartbeat <= 1'b0;
    end else begin
      blink         <= blink + 1'b1;
      led_pass      <= pass & blink[pBLINK_BITS-1];
      led_fail      <= fail;
      led_calib     <= init_calib_complete;
      led_heartbeat <= blink[pBLINK_BITS-1];
    end
  end

  // Shadows load from the pre-update register values, so a snapshot coincident
  // with clear still captures the statistics as they were.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_iteration       <= '0;
      sh_errors          <= '0;
      sh_error_addr      <= '0;
      sh_pass_count      <= '0;
      sh_fail_iteration  <= '0;
      sh_cycles_per_iter <= '0;
      sh_fail_addr       <= '0;
    end else if (snap) begin
      sh_iteration       <= iteration;
      sh_errors          <= errors;
      sh_error_addr      <= error_addr_ext;
      sh_pass_count      <= pass_count;
      sh_fail_iteration  <= fail_iteration;
      sh_cycles_per_iter <= cycles_per_iter;
      sh_fail_addr       <= fail_addr;
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    case (bus.reg_addr)
      5'h00: rd_byte = status_byte;
      5'h01: rd_byte = sh_iteration[7:0];
      5'h02: rd_byte = sh_iteration[15:8];
      5'h03: rd_byte = sh_errors;
      5'h04: rd_byte = sh_error_addr[7:0];
      5'h05: rd_byte = sh_error_addr[15:8];
      5'h06: rd_byte = sh_error_addr[23:16];
      5'h07: rd_byte = sh_error_addr[31:24];
      5'h08: rd_byte = sh_pass_count[7:0];
      5'h09: rd_byte = sh_pass_count[15:8];
      5'h0A: rd_byte = sh_fail_iteration[7:0];
      5'h0B: rd_byte = sh_fail_iteration[15:8];
      5'h0C: rd_byte = sh_cycles_per_iter[7:0];
      5'h0D: rd_byte = sh_cycles_per_iter[15:8];
      5'h0E: rd_byte = sh_cycles_per_iter[23:16];
      5'h0F: rd_byte = sh_cycles_per_iter[31:24];
      5'h10: rd_byte = sh_fail_addr[7:0];
      5'h11: rd_byte = sh_fail_addr[15:8];
      5'h12: rd_byte = sh_fail_addr[23:16];
      5'h13: rd_byte = sh_fail_addr[31:24];
      default: rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.reg_datao <= 8'h00;
    end else if (bus.reg_read) begin
      bus.reg_datao <= rd_byte;
    end
  end

endmodule
